// File: rtl/knn_vote_if.sv
`default_nettype none
// ============================================================================
//  Module   : knn_vote_if
//  Purpose  : Sample-in / result-out handshake bundle for the KNN vote stage.
//  Revision : 1.0 - initial release
// ============================================================================
interface knn_vote_if #(
  parameter int DIST_W  = 17,
  parameter int LABEL_W = 4,
  parameter int VOTE_W  = 3
);
  logic               in_valid;
  logic               in_ready;
  logic [DIST_W-1:0]  in_distance;
  logic [LABEL_W-1:0] in_label;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic [LABEL_W-1:0] out_label;
  logic [VOTE_W-1:0]  out_votes;

  modport master (
    output in_valid, in_distance, in_label, in_last, out_ready,
    input  in_ready, out_valid, out_label, out_votes
  );

  modport slave (
    input  in_valid, in_distance, in_label, in_last, out_ready,
    output in_ready, out_valid, out_label, out_votes
  );
endinterface
`default_nettype wire

// File: rtl/knn_vote.sv
`default_nettype none
// ============================================================================
//  Module   : knn_vote
//  Purpose  : Keeps the K nearest (distance, label) pairs of a query in a
//             sorted list and majority-votes their labels at end of query.
//  Revision : 1.0 - initial release
// ============================================================================
module knn_vote #(
  parameter int DIM_PREC    = 8,
  parameter int K           = 5,
  parameter int LABEL_W     = 4,
  parameter int NUM_CLASSES = 10
) (
  input  logic       clk,
  input  logic       rst,
  knn_vote_if.slave  io_bus
);
  localparam int DIST_W = 2*DIM_PREC+1;
  localparam int VOTE_W = $clog2(K+1);
  localparam logic [LABEL_W-1:0] c_LAST_CLS = LABEL_W'(NUM_CLASSES-1);

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_VOTE    = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;

  logic               r_vld  [K];
  logic [DIST_W-1:0]  r_dist [K];
  logic [LABEL_W-1:0] r_lab  [K];

  logic [LABEL_W-1:0] r_cls;
  logic [LABEL_W-1:0] r_best_lab;
  logic [VOTE_W-1:0]  r_best_cnt;
  logic [LABEL_W-1:0] r_out_lab;
  logic [VOTE_W-1:0]  r_out_cnt;

  logic               w_in_ready;
  logic               w_accept;
  logic               w_out_fire;
  logic [VOTE_W-1:0]  w_cnt;
  logic               w_better;

  logic               w_gt        [K];
  logic               w_take_new  [K];
  logic               w_take_prev [K];
  logic               w_prev_vld  [K];
  logic [DIST_W-1:0]  w_prev_dist [K];
  logic [LABEL_W-1:0] w_prev_lab  [K];

  assign w_in_ready = (r_state == S_COLLECT) && !rst;
  assign w_accept   = io_bus.in_valid && w_in_ready;
  assign w_out_fire = (r_state == S_DONE) && io_bus.out_ready;

  // Invalid slots sit at the tail, so they behave as "farther than anything".
  always_comb begin
    for (int i = 0; i < K; i++) begin
      w_gt[i] = !r_vld[i] || (r_dist[i] > io_bus.in_distance);
    end
  end

  for (genvar gi = 0; gi < K; gi++) begin : g_slot
    if (gi == 0) begin : g_head
      assign w_take_new[gi]  = w_gt[gi];
      assign w_take_prev[gi] = 1'b0;
      assign w_prev_vld[gi]  = 1'b0;
      assign w_prev_dist[gi] = '0;
      assign w_prev_lab[gi]  = '0;
    end else begin : g_body
      assign w_take_new[gi]  = w_gt[gi] && !w_gt[gi-1];
      assign w_take_prev[gi] = w_gt[gi-1];
      assign w_prev_vld[gi]  = r_vld[gi-1];
      assign w_prev_dist[gi] = r_dist[gi-1];
      assign w_prev_lab[gi]  = r_lab[gi-1];
    end
  end

  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < K; i++) begin
      if (r_vld[i] && (r_lab[i] == r_cls)) begin
        w_cnt = w_cnt + VOTE_W'(1);
      end
    end
  end

  assign w_better = (w_cnt > r_best_cnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_COLLECT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_COLLECT: if (w_accept && io_bus.in_last) w_state_nxt = S_VOTE;
      S_VOTE:    if (r_cls == c_LAST_CLS)         w_state_nxt = S_DONE;
      S_DONE:    if (io_bus.out_ready)            w_state_nxt = S_COLLECT;
      default:                                    w_state_nxt = S_COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < K; i++) r_vld[i] <= 1'b0;
      r_cls      <= '0;
      r_best_lab <= '0;
      r_best_cnt <= '0;
      r_out_lab  <= '0;
      r_out_cnt  <= '0;
    end else begin
      case (r_state)
        S_COLLECT: begin
          if (w_accept) begin
            for (int i = 0; i < K; i++) begin
              if (w_take_new[i]) begin
                r_vld[i]  <= 1'b1;
                r_dist[i] <= io_bus.in_distance;
                r_lab[i]  <= io_bus.in_label;
              end else if (w_take_prev[i]) begin
                r_vld[i]  <= w_prev_vld[i];
                r_dist[i] <= w_prev_dist[i];
                r_lab[i]  <= w_prev_lab[i];
              end
            end
            r_cls      <= '0;
            r_best_lab <= '0;
            r_best_cnt <= '0;
          end
        end
        S_VOTE: begin
          r_cls <= r_cls + LABEL_W'(1);
          if (w_better) begin
            r_best_lab <= r_cls;
            r_best_cnt <= w_cnt;
          end
          // Published results only move here, so they hold between queries.
          if (r_cls == c_LAST_CLS) begin
            r_out_lab <= w_better ? r_cls : r_best_lab;
            r_out_cnt <= w_better ? w_cnt : r_best_cnt;
          end
        end
        S_DONE: begin
          if (w_out_fire) begin
            for (int i = 0; i < K; i++) r_vld[i] <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign io_bus.in_ready  = w_in_ready;
  assign io_bus.out_valid = (r_state == S_DONE) && !rst;
  assign io_bus.out_label = r_out_lab;
  assign io_bus.out_votes = r_out_cnt;

endmodule
`default_nettype wire

// File: tb/tb_knn_vote.sv
`default_nettype none
// ============================================================================
//  Module   : tb_knn_vote
//  Purpose  : Directed and random queries against a queue-based KNN model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_knn_vote;
  localparam int K  = 3;
  localparam int NC = 4;
  localparam int LW = 2;
  localparam int DP = 8;
  localparam int DW = 2*DP+1;
  localparam int VW = $clog2(K+1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  knn_vote_if #(.DIST_W(DW), .LABEL_W(LW), .VOTE_W(VW)) bus ();

  knn_vote #(.DIM_PREC(DP), .K(K), .LABEL_W(LW), .NUM_CLASSES(NC)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int prev_label = 0;
  int prev_votes = 0;

  typedef struct {
    int unsigned d;
    int          lab;
  } ent_t;
  ent_t m_list[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void m_insert(input int unsigned d, input int lab);
    int   pos;
    ent_t e;
    pos = m_list.size();
    for (int i = 0; i < m_list.size(); i++) begin
      if (m_list[i].d > d) begin
        pos = i;
        break;
      end
    end
    if (pos >= K) return;
    e.d   = d;
    e.lab = lab;
    m_list.insert(pos, e);
    if (m_list.size() > K) void'(m_list.pop_back());
  endfunction

  function automatic void m_vote(output int lab, output int votes);
    int cnt [NC];
    for (int c = 0; c < NC; c++) cnt[c] = 0;
    foreach (m_list[i]) if (m_list[i].lab < NC) cnt[m_list[i].lab]++;
    lab   = 0;
    votes = 0;
    for (int c = 0; c < NC; c++) begin
      if (cnt[c] > votes) begin
        lab   = c;
        votes = cnt[c];
      end
    end
  endfunction

  task automatic drive_idle();
    bus.in_valid    = 1'b0;
    bus.in_last     = 1'b0;
    bus.in_distance = '0;
    bus.in_label    = '0;
  endtask

  task automatic send(input int unsigned d, input int lab, input bit last);
    bus.in_valid    = 1'b1;
    bus.in_distance = d[DW-1:0];
    bus.in_label    = lab[LW-1:0];
    bus.in_last     = last;
    check("in_ready_collect", bus.in_ready, 1);
    @(posedge clk); #1;
    drive_idle();
    m_insert(d, lab);
  endtask

  task automatic get_result(input int bp, input bit garbage);
    int el, ev, n;
    m_vote(el, ev);
    bus.out_ready = (bp == 0);
    if (garbage) begin
      bus.in_valid    = 1'b1;
      bus.in_distance = '0;
      bus.in_label    = '0;
      bus.in_last     = 1'b1;
    end
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 50) begin
      check("in_ready_busy", bus.in_ready, 0);
      check("hold_label", bus.out_label, prev_label);
      check("hold_votes", bus.out_votes, prev_votes);
      @(posedge clk); #1;
      n++;
    end
    check("latency", n, NC);
    check("out_valid", bus.out_valid, 1);
    check("out_label", bus.out_label, el);
    check("out_votes", bus.out_votes, ev);
    for (int i = 0; i < bp; i++) begin
      @(posedge clk); #1;
      check("bp_valid", bus.out_valid, 1);
      check("bp_label", bus.out_label, el);
      check("bp_votes", bus.out_votes, ev);
      check("bp_in_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    drive_idle();
    check("valid_drop", bus.out_valid, 0);
    check("in_ready_back", bus.in_ready, 1);
    check("label_held", bus.out_label, el);
    prev_label = el;
    prev_votes = ev;
    m_list.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, mode, lab;
    int unsigned d;
    rst = 1'b1;
    drive_idle();
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_label", bus.out_label, 0);
    check("rst_out_votes", bus.out_votes, 0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", bus.in_ready, 1);

    // Basic vote
    send(10, 1, 0); send(5, 2, 0); send(7, 2, 0); send(20, 0, 0); send(3, 1, 1);
    get_result(0, 0);

    // Reset mid-query
    send(4, 0, 0); send(4, 0, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_in_ready", bus.in_ready, 0);
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_out_label", bus.out_label, 0);
    check("midrst_out_votes", bus.out_votes, 0);
    rst = 1'b0;
    #1;
    check("midrst_ready_back", bus.in_ready, 1);
    m_list.delete();
    prev_label = 0;
    prev_votes = 0;
    send(6, 2, 1);
    get_result(0, 0);

    // Ties A, with backpressure and garbage on the input
    send(5, 0, 0); send(5, 1, 0); send(5, 2, 0); send(5, 3, 1);
    get_result(10, 1);
    // Short query; stray garbage (0,L0) would win the tie here
    send(8, 3, 1);
    get_result(0, 0);
    // Ties B
    send(1, 3, 0); send(2, 1, 0); send(9, 0, 1);
    get_result(2, 1);
    // Extreme distance
    send((1 << DW) - 1, 2, 0); send(0, 1, 1);
    get_result(0, 0);

    // Random queries
    for (int q = 0; q < 40; q++) begin
      len = $urandom_range(1, 6);
      for (int s = 0; s < len; s++) begin
        mode = $urandom_range(0, 3);
        case (mode)
          0:       d = $urandom_range(0, 7);
          1:       d = (1 << DW) - 1;
          default: d = $urandom & ((1 << DW) - 1);
        endcase
        lab = $urandom_range(0, NC-1);
        send(d, lab, s == len-1);
      end
      get_result($urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/knn_vote.md
# knn_vote

Streaming consumer of the distance datapath. Accepts one (distance, label) pair per cycle for a query, keeps the K smallest distances in a sorted insertion list, and on end-of-query performs a majority vote over the kept labels. It returns the winning class and its vote count on a valid/ready output. It sits directly downstream of the distance unit and closes the KNN classification loop.

## Interface
- DIM_PREC, from defs.sv: per-dimension precision; distance width DIST_W = 2*DIM_PREC+1.
- K, 5: number of nearest neighbours kept; K >= 1.
- LABEL_W, 4: label width.
- NUM_CLASSES, 10: number of votable classes; 1 <= NUM_CLASSES <= 2**LABEL_W.
- VOTE_W (derived, not overridable): $clog2(K+1).

- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample.
- in_distance  in  DIST_W  squared distance, unsigned.
- in_label  in  LABEL_W  class label of the reference point.
- in_last  in  1  marks the final sample of the query.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_label  out  LABEL_W  winning class.
- out_votes  out  VOTE_W  votes for the winning class.

## Operation
- State machine: COLLECT -> VOTE -> DONE -> COLLECT.
- COLLECT
  - in_ready=1.
  - A sample is accepted when in_valid&&in_ready.
  - It is inserted into a K-entry list sorted ascending by distance. Each entry holds {valid, distance, label}.
  - Entries with distance strictly greater than the new sample shift one slot toward the tail. The new sample lands after all entries with equal or smaller distance, so the earlier arrival wins ties.
  - List not full: the sample is always inserted and the valid count grows by 1.
  - List full: a sample with distance >= tail distance is dropped. Otherwise the tail is evicted.
  - Accepting a sample with in_last=1 inserts it under the same rules, then moves to VOTE.
- VOTE
  - in_ready=0.
  - Exactly NUM_CLASSES cycles; class counter c = 0..NUM_CLASSES-1.
  - Each cycle, count the valid entries with label==c.
  - If count > best_count (strict), update best_label=c and best_count=count. Ties therefore resolve to the lowest class index.
  - Labels >= NUM_CLASSES occupy list slots but never receive votes.
  - best_count starts at 0 and best_label at 0.
- DONE
  - out_valid=1 with out_label=best_label and out_votes=best_count.
  - Outputs are held stable until out_valid&&out_ready.
  - On that handshake: clear all list valid bits, return to COLLECT.
- in_valid is ignored outside COLLECT.
- in_distance is unsigned. The full range 0..2**DIST_W-1 is legal, including the all-ones value.

## Timing
- Reset:
  - state=COLLECT, list cleared, in_ready=0 while rst=1.
  - out_valid=0, out_label=0, out_votes=0.
  - in_ready=1 in the first cycle after rst deasserts.
- Throughput in COLLECT: one sample per cycle, no bubbles. An insertion at edge t is visible in the list at t+1.
- Latency: in_last accepted at edge t gives VOTE during cycles t+1..t+NUM_CLASSES and out_valid=1 from cycle t+NUM_CLASSES+1.
- Result handshake at edge u gives out_valid=0 and in_ready=1 from cycle u+1. Minimum gap between the last sample of one query and the first sample of the next is NUM_CLASSES+1 cycles.
- out_label and out_votes may change only on leaving VOTE or on reset. Between results they hold their last values.
- Reset mid-operation, in any state, aborts the query and discards the list and any pending result; no partial result is emitted.
- A query always has at least one sample (in_last rides on a valid sample), so out_votes >= 1 whenever any kept label is < NUM_CLASSES.

## Test plan
All scenarios use K=3, NUM_CLASSES=4, LABEL_W=2, DIM_PREC=8.
- Basic vote:
  - Stimulus: stream (10,L1),(5,L2),(7,L2),(20,L0),(3,L1,last).
  - Required: list {3:L1, 5:L2, 7:L2}; out_label=2, out_votes=2; out_valid rises exactly 5 cycles after the last accept.
- Tie handling:
  - Stimulus A: (5,L0),(5,L1),(5,L2),(5,L3,last).
  - Required A: the last sample is dropped; out_label=0, out_votes=1.
  - Stimulus B: (1,L3),(2,L1),(9,L0,last).
  - Required B: out_label=0, out_votes=1.
- Short query:
  - Stimulus: a single (8,L3,last).
  - Required: out_label=3, out_votes=1.
- Extreme distance:
  - Stimulus: (2**17-1,L2),(0,L1,last).
  - Required: both kept; out_label=1, out_votes=1.
- Backpressure:
  - Stimulus: hold out_ready=0 for 10 cycles while driving in_valid=1 with garbage.
  - Required: out_valid, out_label and out_votes are stable and in_ready=0 throughout. out_ready=1 completes the handshake, with in_ready=1 the next cycle. The garbage is never inserted.
- Reset mid-query:
  - Stimulus: after (4,L0),(4,L0), pulse rst for one cycle, then send (6,L2,last).
  - Required: out_valid=0, out_label=0 and out_votes=0 after reset; the next result is out_label=2, out_votes=1 (no stale entries).
  - Also run back-to-back queries with out_ready tied high; each result must be independent.
